alu_uart_sequencer: RTL and testbench

- Front end of the ALU: sits between the UART receiver/transmitter pair and the combinational ALU.
- Collects three received bytes in order: operand A, operand B, opcode.
- Drives them onto the ALU inputs, captures the ALU result one cycle later, and hands it to the UART transmitter with a start/done handshake.
- A byte-gap timeout recovers from lost bytes.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_uart_sequencer_if.sv | 40 ++++
 rtl/gap_timer.sv | 30 +++
 rtl/alu_uart_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_uart_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, sequencer state encoding, opcode legality.
package alu_pkg;

    localparam int unsigned OP_BYTE_W = 8;

    localparam logic [OP_BYTE_W-1:0] OP_ADD = 8'h20;
    localparam logic [OP_BYTE_W-1:0] OP_SUB = 8'h22;
    localparam logic [OP_BYTE_W-1:0] OP_AND = 8'h24;
    localparam logic [OP_BYTE_W-1:0] OP_OR  = 8'h25;
    localparam logic [OP_BYTE_W-1:0] OP_XOR = 8'h26;
    localparam logic [OP_BYTE_W-1:0] OP_NOR = 8'h27;
    localparam logic [OP_BYTE_W-1:0] OP_SRL = 8'h02;
    localparam logic [OP_BYTE_W-1:0] OP_SRA = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_EXEC,
        ST_SEND,
        ST_WAIT_TX
    } seq_state_t;

    function automatic logic is_valid_op(input logic [OP_BYTE_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRL, OP_SRA: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_uart_sequencer_if.sv
// UART/ALU side bundle of the sequencer; op_err exists only with ALU_SEQ_OPCHECK_EN.
interface alu_uart_sequencer_if #(
    parameter int unsigned N_BITS = 8,
    parameter int unsigned N_OP   = 6
);
    logic              rx_done;
    logic [N_BITS-1:0] rx_data;
    logic              tx_done;
    logic [N_BITS-1:0] alu_result;
    logic [N_BITS-1:0] alu_a;
    logic [N_BITS-1:0] alu_b;
    logic [N_OP-1:0]   alu_op;
    logic [N_BITS-1:0] tx_data;
    logic              tx_start;
    logic              busy;
    logic              overrun;
    logic              timeout;
`ifdef ALU_SEQ_OPCHECK_EN
    logic              op_err;
`endif

    // Sequencer side
    modport master (
`ifdef ALU_SEQ_OPCHECK_EN
        output op_err,
`endif
        input  rx_done, rx_data, tx_done, alu_result,
        output alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun, timeout
    );

    // UART/ALU environment side
    modport slave (
`ifdef ALU_SEQ_OPCHECK_EN
        input  op_err,
`endif
        output rx_done, rx_data, tx_done, alu_result,
        input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun, timeout
    );

endinterface

// File: rtl/gap_timer.sv
// Byte-gap counter: clears on clr, counts while en, flags the terminal count combinationally.
module gap_timer
    import alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc_c = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects A, B, opcode bytes from UART RX, runs the ALU and hands the result to UART TX.
// Optional opcode legality check: define ALU_SEQ_OPCHECK_EN.
module alu_uart_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned N_BITS         = 8,
    parameter int unsigned N_OP           = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_uart_sequencer_if.master bus
);

    seq_state_t        state;
    logic              in_gap;
    logic              gap_tc_c;
    logic [N_BITS-1:0] rx_byte;
    logic [N_OP-1:0]   rx_op;

    assign rx_byte = bus.rx_data;
    assign rx_op   = rx_byte[N_OP-1:0];
    assign in_gap  = (state == ST_WAIT_B) || (state == ST_WAIT_OP);

    // Gap count restarts whenever the FSM is outside the byte-wait states or a byte arrives
    gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!in_gap || bus.rx_done),
        .en      (in_gap),
        .tc_c    (gap_tc_c)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_op   <= '0;
            bus.tx_data  <= '0;
            bus.tx_start <= 1'b0;
            bus.busy     <= 1'b0;
            bus.overrun  <= 1'b0;
            bus.timeout  <= 1'b0;
`ifdef ALU_SEQ_OPCHECK_EN
            bus.op_err   <= 1'b0;
`endif
        end else begin
            bus.tx_start <= 1'b0;
            bus.timeout  <= 1'b0;
`ifdef ALU_SEQ_OPCHECK_EN
            bus.op_err   <= 1'b0;
`endif
            // Bytes arriving while a result is in flight are dropped
            if (bus.rx_done && (state inside {ST_EXEC, ST_SEND, ST_WAIT_TX})) begin
                bus.overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.rx_done) begin
                        bus.alu_a <= rx_byte;
                        bus.busy  <= 1'b1;
                        state     <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (bus.rx_done) begin
                        bus.alu_b <= rx_byte;
                        state     <= ST_WAIT_OP;
                    end else if (gap_tc_c) begin
                        bus.timeout <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_WAIT_OP: begin
                    if (bus.rx_done) begin
`ifdef ALU_SEQ_OPCHECK_EN
                        if (is_valid_op(OP_BYTE_W'(rx_op))) begin
                            bus.alu_op <= rx_op;
                            state      <= ST_EXEC;
                        end else begin
                            bus.op_err <= 1'b1;
                            bus.busy   <= 1'b0;
                            state      <= ST_IDLE;
                        end
`else
                        bus.alu_op <= rx_op;
                        state      <= ST_EXEC;
`endif
                    end else if (gap_tc_c) begin
                        bus.timeout <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    bus.tx_data  <= bus.alu_result;
                    bus.tx_start <= 1'b1;
                    state        <= ST_SEND;
                end
                ST_SEND: begin
                    state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (bus.tx_done) begin
                        bus.busy <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Scoreboard bench for alu_uart_sequencer with a behavioural ALU and an auto-responding UART TX.
module tb_alu_uart_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   tx_count = 0;
    int   last_rx = 0;
    logic [7:0] exp_q[$];

    alu_uart_sequencer_if #(.N_BITS(8), .N_OP(6)) bus ();

    alu_uart_sequencer #(
        .N_BITS(8),
        .N_OP(6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (8'(op))
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRL:  return a >> b;
            OP_SRA:  return 8'($signed(a) >>> b);
            default: return 8'h00;
        endcase
    endfunction

    assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_alu_a"},    32'(bus.alu_a),    32'h0);
        check({tag, "_alu_b"},    32'(bus.alu_b),    32'h0);
        check({tag, "_alu_op"},   32'(bus.alu_op),   32'h0);
        check({tag, "_tx_data"},  32'(bus.tx_data),  32'h0);
        check({tag, "_tx_start"}, 32'(bus.tx_start), 32'h0);
        check({tag, "_busy"},     32'(bus.busy),     32'h0);
        check({tag, "_overrun"},  32'(bus.overrun),  32'h0);
        check({tag, "_timeout"},  32'(bus.timeout),  32'h0);
`ifdef ALU_SEQ_OPCHECK_EN
        check({tag, "_op_err"},   32'(bus.op_err),   32'h0);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        @(posedge clk);
        #1;
        bus.rx_done = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input logic [7:0] exp);
        send_byte(a);
        send_byte(b);
        exp_q.push_back(exp);
        send_byte(op);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
        check(tag, 32'(bus.busy), 32'h0);
    endtask

    task automatic wait_tx(input int prev);
        for (int i = 0; i < 50 && tx_count == prev; i++) @(negedge clk);
        check("wait_tx_start", 32'(tx_count), 32'(prev + 1));
    endtask

    // Output monitor: scoreboard, latency and pulse width of tx_start
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rx_done) last_rx = cyc;
            if (bus.tx_start) begin
                tx_count++;
                check("tx_latency", 32'(cyc - last_rx), 32'd2);
                if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else check("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                @(negedge clk);
                check("tx_start_pulse", 32'(bus.tx_start), 32'h0);
            end
        end
    end

    // UART TX model: tx_done 10 cycles after tx_start
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_start) begin
                repeat (10) @(posedge clk);
                #1;
                bus.tx_done = 1'b1;
                @(negedge clk);
                check("busy_before_done", 32'(bus.busy), 32'h1);
                @(posedge clk);
                #1;
                bus.tx_done = 1'b0;
                check("busy_after_done", 32'(bus.busy), 32'h0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        reset_n     = 1'b0;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        bus.tx_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Basic ADD with operand capture
        send_cmd(8'h05, 8'h03, 8'h20, 8'h08);
        check("add_alu_a", 32'(bus.alu_a), 32'h05);
        check("add_alu_b", 32'(bus.alu_b), 32'h03);
        check("add_alu_op", 32'(bus.alu_op), 32'h20);
        check("add_busy", 32'(bus.busy), 32'h1);
        wait_idle("add_idle");

        // Shifts
        send_cmd(8'h80, 8'h02, 8'h03, 8'hE0);
        wait_idle("sra_idle");
        send_cmd(8'h80, 8'h02, 8'h02, 8'h20);
        wait_idle("srl_idle");

        // Timeout after a lone operand byte
        n = tx_count;
        send_byte(8'h11);
        begin
            int hit;
            hit = 0;
            for (int i = 1; i <= 40 && hit == 0; i++) begin
                @(posedge clk);
                #1;
                if (bus.timeout) hit = i;
            end
            check("timeout_delay", 32'(hit), 32'd16);
        end
        check("timeout_idle", 32'(bus.busy), 32'h0);
        check("timeout_alu_a", 32'(bus.alu_a), 32'h11);
        @(posedge clk);
        #1;
        check("timeout_pulse", 32'(bus.timeout), 32'h0);
        check("timeout_no_tx", 32'(tx_count), 32'(n));

        // Byte landing on the terminal count is accepted
        send_byte(8'h01);
        repeat (14) @(posedge clk);
        send_byte(8'h01);
        check("tc_byte_no_timeout", 32'(bus.timeout), 32'h0);
        check("tc_byte_busy", 32'(bus.busy), 32'h1);
        check("tc_byte_alu_b", 32'(bus.alu_b), 32'h01);
        exp_q.push_back(8'h00);
        send_byte(8'h22);
        wait_idle("sub_idle");
        check("overrun_clear", 32'(bus.overrun), 32'h0);

        // Overrun during WAIT_TX, sticky, next command still works
        n = tx_count;
        send_cmd(8'h12, 8'h34, 8'h24, 8'h10);
        wait_tx(n);
        send_byte(8'h55);
        check("overrun_set", 32'(bus.overrun), 32'h1);
        check("overrun_busy", 32'(bus.busy), 32'h1);
        wait_idle("overrun_idle");
        send_cmd(8'h0F, 8'hF0, 8'h25, 8'hFF);
        wait_idle("or_idle");
        check("overrun_sticky", 32'(bus.overrun), 32'h1);

        // Reset between operand B and opcode
        send_byte(8'h07);
        send_byte(8'h09);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("midreset");
        reset_n = 1'b1;
        send_byte(8'h20);
        check("midreset_alu_a", 32'(bus.alu_a), 32'h20);
        check("midreset_busy", 32'(bus.busy), 32'h1);
        send_byte(8'h01);
        exp_q.push_back(8'h21);
        send_byte(8'h20);
        wait_idle("midreset_idle");

        // Illegal opcode
        n = tx_count;
`ifdef ALU_SEQ_OPCHECK_EN
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h3F);
        check("op_err_pulse", 32'(bus.op_err), 32'h1);
        check("op_err_idle", 32'(bus.busy), 32'h0);
        check("op_err_alu_op", 32'(bus.alu_op), 32'h20);
        @(posedge clk);
        #1;
        check("op_err_width", 32'(bus.op_err), 32'h0);
        repeat (5) @(posedge clk);
        check("op_err_no_tx", 32'(tx_count), 32'(n));
`else
        send_cmd(8'h01, 8'h02, 8'h3F, 8'h00);
        check("illegal_alu_op", 32'(bus.alu_op), 32'h3F);
        wait_idle("illegal_idle");
        check("illegal_tx", 32'(tx_count), 32'(n + 1));
`endif

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef ALU_SEQ_OPCHECK_EN
        check("tx_total", 32'(tx_count), 32'd7);
`else
        check("tx_total", 32'(tx_count), 32'd8);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
